// File: rtl/axi_lite_up_pkg.sv
// Shared definitions for the AXI4-Lite to up_* bridge: FSM state encodings,
// AXI response codes and the read data returned when a read times out.
package axi_lite_up_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_WAIT = 2'd2,
        W_RESP = 2'd3
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_WAIT = 2'd2,
        R_RESP = 2'd3
    } rd_state_t;

    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [1:0]  RESP_SLVERR   = 2'b10;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_DEAD;

    // Counter width able to reach cycles-1; never narrower than one bit.
    function automatic int unsigned timer_width(input int unsigned cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/axi_lite_up_timer.sv
// Ack-wait timer: cleared when a request is issued, counts while waiting,
// and flags expiry on the last permitted wait cycle.
module axi_lite_up_timer
    import axi_lite_up_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic up_clk,
    input  logic up_rstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned TW = timer_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] count;

    always_ff @(posedge up_clk) begin
        if (!up_rstn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TW'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/axi_lite_up_bridge.sv
// AXI4-Lite slave driving the up_* request/acknowledge register bus.
// Independent write and read engines, each bounded by an ack timeout.
module axi_lite_up_bridge
    import axi_lite_up_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned UP_ADDR_WIDTH  = 14,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                     up_clk,
    input  logic                     up_rstn,

    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [ADDR_WIDTH-1:0]    s_axi_awaddr,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    input  logic [31:0]              s_axi_wdata,
    input  logic [3:0]               s_axi_wstrb,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    output logic [1:0]               s_axi_bresp,

    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    input  logic [ADDR_WIDTH-1:0]    s_axi_araddr,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    output logic [31:0]              s_axi_rdata,
    output logic [1:0]               s_axi_rresp,

    output logic                     up_wreq,
    output logic [UP_ADDR_WIDTH-1:0] up_waddr,
    output logic [31:0]              up_wdata,
    input  logic                     up_wack,
    output logic                     up_rreq,
    output logic [UP_ADDR_WIDTH-1:0] up_raddr,
    input  logic [31:0]              up_rdata,
    input  logic                     up_rack
);

    wr_state_t w_state;
    rd_state_t r_state;

    logic                     aw_held;
    logic                     w_held;
    logic [UP_ADDR_WIDTH-1:0] awaddr_q;
    logic [31:0]              wdata_q;

    logic w_expired;
    logic r_expired;

    // Byte strobes and byte-offset bits carry no meaning on the word-wide up_* bus.
    logic unused_inputs;
    assign unused_inputs = ^{s_axi_wstrb, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    logic                     aw_fire;
    logic                     w_fire;
    logic                     aw_held_nx;
    logic                     w_held_nx;
    logic [UP_ADDR_WIDTH-1:0] awaddr_word;
    logic [UP_ADDR_WIDTH-1:0] araddr_word;

    always_comb begin
        aw_fire     = s_axi_awvalid && s_axi_awready;
        w_fire      = s_axi_wvalid && s_axi_wready;
        aw_held_nx  = aw_held || aw_fire;
        w_held_nx   = w_held || w_fire;
        awaddr_word = s_axi_awaddr[ADDR_WIDTH-1:2];
        araddr_word = s_axi_araddr[ADDR_WIDTH-1:2];
    end

    axi_lite_up_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wr_timer (
        .up_clk  (up_clk),
        .up_rstn (up_rstn),
        .clear   (w_state == W_REQ),
        .enable  (w_state == W_WAIT),
        .expired (w_expired)
    );

    axi_lite_up_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rd_timer (
        .up_clk  (up_clk),
        .up_rstn (up_rstn),
        .clear   (r_state == R_REQ),
        .enable  (r_state == R_WAIT),
        .expired (r_expired)
    );

    // Write engine. The request is loaded from the live bus when the last
    // half of the AW/W pair arrives in the same cycle it completes the pair.
    always_ff @(posedge up_clk) begin
        if (!up_rstn) begin
            w_state       <= W_IDLE;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= '0;
            up_wreq       <= 1'b0;
            up_waddr      <= '0;
            up_wdata      <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_fire) begin
                        aw_held  <= 1'b1;
                        awaddr_q <= awaddr_word;
                    end
                    if (w_fire) begin
                        w_held  <= 1'b1;
                        wdata_q <= s_axi_wdata;
                    end
                    if (aw_held_nx && w_held_nx) begin
                        w_state       <= W_REQ;
                        up_wreq       <= 1'b1;
                        up_waddr      <= aw_fire ? awaddr_word : awaddr_q;
                        up_wdata      <= w_fire ? s_axi_wdata : wdata_q;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b0;
                    end else begin
                        s_axi_awready <= !aw_held_nx;
                        s_axi_wready  <= !w_held_nx;
                    end
                end
                W_REQ: begin
                    up_wreq <= 1'b0;
                    w_state <= W_WAIT;
                end
                W_WAIT: begin
                    if (up_wack) begin
                        s_axi_bresp  <= RESP_OKAY;
                        s_axi_bvalid <= 1'b1;
                        w_state      <= W_RESP;
                    end else if (w_expired) begin
                        s_axi_bresp  <= RESP_SLVERR;
                        s_axi_bvalid <= 1'b1;
                        w_state      <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        aw_held       <= 1'b0;
                        w_held        <= 1'b0;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge up_clk) begin
        if (!up_rstn) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= '0;
            up_rreq       <= 1'b0;
            up_raddr      <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s_axi_arvalid && s_axi_arready) begin
                        s_axi_arready <= 1'b0;
                        up_rreq       <= 1'b1;
                        up_raddr      <= araddr_word;
                        r_state       <= R_REQ;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_REQ: begin
                    up_rreq <= 1'b0;
                    r_state <= R_WAIT;
                end
                R_WAIT: begin
                    if (up_rack) begin
                        s_axi_rdata  <= up_rdata;
                        s_axi_rresp  <= RESP_OKAY;
                        s_axi_rvalid <= 1'b1;
                        r_state      <= R_RESP;
                    end else if (r_expired) begin
                        s_axi_rdata  <= TIMEOUT_RDATA;
                        s_axi_rresp  <= RESP_SLVERR;
                        s_axi_rvalid <= 1'b1;
                        r_state      <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                        r_state       <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_up_bridge.sv
// Directed bench for axi_lite_up_bridge with a delay-programmable up_* responder.
`timescale 1ns/1ps
module tb_axi_lite_up_bridge;

    localparam int AW = 16;
    localparam int UW = 14;
    localparam int TO = 64;

    logic          up_clk;
    logic          up_rstn;
    logic          s_axi_awvalid, s_axi_awready;
    logic [AW-1:0] s_axi_awaddr;
    logic          s_axi_wvalid, s_axi_wready;
    logic [31:0]   s_axi_wdata;
    logic [3:0]    s_axi_wstrb;
    logic          s_axi_bvalid, s_axi_bready;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_arvalid, s_axi_arready;
    logic [AW-1:0] s_axi_araddr;
    logic          s_axi_rvalid, s_axi_rready;
    logic [31:0]   s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          up_wreq;
    logic [UW-1:0] up_waddr;
    logic [31:0]   up_wdata;
    logic          up_wack;
    logic          up_rreq;
    logic [UW-1:0] up_raddr;
    logic [31:0]   up_rdata;
    logic          up_rack;

    axi_lite_up_bridge #(
        .ADDR_WIDTH     (AW),
        .UP_ADDR_WIDTH  (UW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .up_clk        (up_clk),
        .up_rstn       (up_rstn),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .up_wreq       (up_wreq),
        .up_waddr      (up_waddr),
        .up_wdata      (up_wdata),
        .up_wack       (up_wack),
        .up_rreq       (up_rreq),
        .up_raddr      (up_raddr),
        .up_rdata      (up_rdata),
        .up_rack       (up_rack)
    );

    initial begin
        up_clk = 1'b0;
        forever #5 up_clk = ~up_clk;
    end

    int vectors = 0;
    int miscompares = 0;

    // Responder controls: ack delay in cycles after the request cycle (0 = never).
    int          wack_dly = 0;
    int          rack_dly = 0;
    logic [31:0] rdata_val = 32'h0;
    logic        force_rack = 1'b0;
    int          wreq_count = 0;
    int          rreq_count = 0;

    initial begin : responder
        int wcnt;
        int rcnt;
        wcnt = 0;
        rcnt = 0;
        up_wack = 1'b0;
        up_rack = 1'b0;
        up_rdata = 32'h5555_AAAA;
        forever begin
            @(negedge up_clk);
            up_wack = 1'b0;
            up_rack = 1'b0;
            if (wcnt > 0) begin
                wcnt--;
                if (wcnt == 0) up_wack = 1'b1;
            end
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) up_rack = 1'b1;
            end
            if (up_wreq) begin
                wreq_count++;
                if (wack_dly > 0) wcnt = wack_dly;
            end
            if (up_rreq) begin
                rreq_count++;
                if (rack_dly > 0) rcnt = rack_dly;
            end
            if (force_rack) up_rack = 1'b1;
            up_rdata = up_rack ? (force_rack ? 32'h1111_2222 : rdata_val) : 32'h5555_AAAA;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge up_clk);
        #1;
    endtask

    task automatic test_reset();
        up_rstn = 1'b0;
        step();
        step();
        step();
        vectors++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
             s_axi_rvalid, s_axi_rdata, s_axi_rresp, up_wreq, up_waddr, up_wdata,
             up_rreq, up_raddr} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: outputs not all zero (awr=%b wr=%b arr=%b bv=%b rv=%b)",
                     s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid);
        end
        up_rstn = 1'b1;
        step();
        vectors++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_ready: awready/wready/arready=%b%b%b expected 111",
                     s_axi_awready, s_axi_wready, s_axi_arready);
        end
    endtask

    task automatic test_write_same_cycle();
        int base;
        base = wreq_count;
        wack_dly = 1;
        s_axi_bready  = 1'b1;
        s_axi_awvalid = 1'b1;
        s_axi_awaddr  = 16'h0040;
        s_axi_wvalid  = 1'b1;
        s_axi_wdata   = 32'h1234_5678;
        step();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        vectors++;
        if ({up_wreq, up_waddr, up_wdata} !== {1'b1, 14'h010, 32'h1234_5678}) begin
            miscompares++;
            $display("FAIL wr_same_req: wreq=%b waddr=%h wdata=%h expected 1/010/12345678",
                     up_wreq, up_waddr, up_wdata);
        end
        vectors++;
        if ({s_axi_awready, s_axi_wready} !== 2'b00) begin
            miscompares++;
            $display("FAIL wr_same_ready: awready/wready=%b%b expected 00", s_axi_awready, s_axi_wready);
        end
        step();
        vectors++;
        if ({up_wreq, s_axi_bvalid} !== 2'b00) begin
            miscompares++;
            $display("FAIL wr_same_wait: wreq=%b bvalid=%b expected 0/0", up_wreq, s_axi_bvalid);
        end
        step();
        vectors++;
        if ({s_axi_bvalid, s_axi_bresp} !== 3'b100) begin
            miscompares++;
            $display("FAIL wr_same_resp: bvalid=%b bresp=%b expected 1/00", s_axi_bvalid, s_axi_bresp);
        end
        step();
        vectors++;
        if ({s_axi_bvalid, s_axi_awready, s_axi_wready} !== 3'b011) begin
            miscompares++;
            $display("FAIL wr_same_done: bvalid=%b awready=%b wready=%b expected 0/1/1",
                     s_axi_bvalid, s_axi_awready, s_axi_wready);
        end
        vectors++;
        if (wreq_count - base !== 1) begin
            miscompares++;
            $display("FAIL wr_same_pulses: %0d up_wreq cycles, expected 1", wreq_count - base);
        end
    endtask

    task automatic test_w_before_aw();
        int base;
        int n;
        int bseen;
        base = wreq_count;
        wack_dly = 2;
        s_axi_bready = 1'b1;
        s_axi_wvalid = 1'b1;
        s_axi_wdata  = 32'hA5A5_0001;
        step();
        s_axi_wvalid = 1'b0;
        vectors++;
        if ({s_axi_wready, s_axi_awready} !== 2'b01) begin
            miscompares++;
            $display("FAIL w_first_ready: wready/awready=%b%b expected 01", s_axi_wready, s_axi_awready);
        end
        for (int i = 0; i < 4; i++) step();
        vectors++;
        if (wreq_count - base !== 0) begin
            miscompares++;
            $display("FAIL w_first_early: %0d up_wreq cycles before AW, expected 0", wreq_count - base);
        end
        s_axi_awvalid = 1'b1;
        s_axi_awaddr  = 16'h0104;
        step();
        s_axi_awvalid = 1'b0;
        vectors++;
        if ({up_wreq, up_waddr, up_wdata} !== {1'b1, 14'h041, 32'hA5A5_0001}) begin
            miscompares++;
            $display("FAIL w_first_req: wreq=%b waddr=%h wdata=%h expected 1/041/a5a50001",
                     up_wreq, up_waddr, up_wdata);
        end
        n = 0;
        while (!s_axi_bvalid && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (n !== 3 || s_axi_bresp !== 2'b00) begin
            miscompares++;
            $display("FAIL w_first_resp: bvalid after %0d cycles bresp=%b, expected 3 cycles bresp=00",
                     n, s_axi_bresp);
        end
        bseen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (s_axi_bvalid) bseen++;
        end
        vectors++;
        if (bseen !== 0 || wreq_count - base !== 1) begin
            miscompares++;
            $display("FAIL w_first_once: extra bvalid cycles=%0d wreq cycles=%0d, expected 0 and 1",
                     bseen, wreq_count - base);
        end
    endtask

    task automatic test_read_ack();
        rack_dly  = 2;
        rdata_val = 32'hCAFE_F00D;
        s_axi_rready  = 1'b0;
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = 16'h0008;
        step();
        s_axi_arvalid = 1'b0;
        vectors++;
        if ({up_rreq, up_raddr, s_axi_arready} !== {1'b1, 14'h002, 1'b0}) begin
            miscompares++;
            $display("FAIL rd_ack_req: rreq=%b raddr=%h arready=%b expected 1/002/0",
                     up_rreq, up_raddr, s_axi_arready);
        end
        step();
        step();
        vectors++;
        if ({up_rreq, s_axi_rvalid} !== 2'b00) begin
            miscompares++;
            $display("FAIL rd_ack_wait: rreq=%b rvalid=%b expected 0/0", up_rreq, s_axi_rvalid);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({s_axi_rvalid, s_axi_rdata, s_axi_rresp} !== {1'b1, 32'hCAFE_F00D, 2'b00}) begin
                miscompares++;
                $display("FAIL rd_ack_hold[%0d]: rvalid=%b rdata=%h rresp=%b expected 1/cafef00d/00",
                         i, s_axi_rvalid, s_axi_rdata, s_axi_rresp);
            end
            if (i < 3) step();
        end
        s_axi_rready = 1'b1;
        step();
        vectors++;
        if ({s_axi_rvalid, s_axi_arready} !== 2'b01) begin
            miscompares++;
            $display("FAIL rd_ack_done: rvalid=%b arready=%b expected 0/1", s_axi_rvalid, s_axi_arready);
        end
    endtask

    task automatic test_read_timeout();
        int n;
        rack_dly = 0;
        s_axi_rready  = 1'b0;
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = 16'h0ABC;
        step();
        s_axi_arvalid = 1'b0;
        step();
        n = 0;
        while (!s_axi_rvalid && n < 200) begin
            step();
            n++;
        end
        vectors++;
        if (n !== 64 || s_axi_rdata !== 32'hDEAD_DEAD || s_axi_rresp !== 2'b10) begin
            miscompares++;
            $display("FAIL rd_timeout: rvalid after %0d cycles rdata=%h rresp=%b, expected 64/deaddead/10",
                     n, s_axi_rdata, s_axi_rresp);
        end
        force_rack = 1'b1;
        step();
        force_rack = 1'b0;
        vectors++;
        if ({s_axi_rvalid, s_axi_rdata, s_axi_rresp} !== {1'b1, 32'hDEAD_DEAD, 2'b10}) begin
            miscompares++;
            $display("FAIL rd_late_ack: rvalid=%b rdata=%h rresp=%b expected 1/deaddead/10",
                     s_axi_rvalid, s_axi_rdata, s_axi_rresp);
        end
        s_axi_rready = 1'b1;
        step();
        step();
        vectors++;
        if ({s_axi_rvalid, s_axi_arready} !== 2'b01) begin
            miscompares++;
            $display("FAIL rd_timeout_done: rvalid=%b arready=%b expected 0/1", s_axi_rvalid, s_axi_arready);
        end
    endtask

    task automatic test_write_timeout();
        int n;
        s_axi_bready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            wack_dly = (pass == 0) ? 0 : 64;
            s_axi_awvalid = 1'b1;
            s_axi_awaddr  = 16'h0F00;
            s_axi_wvalid  = 1'b1;
            s_axi_wdata   = 32'h0000_00F0 + pass;
            step();
            s_axi_awvalid = 1'b0;
            s_axi_wvalid  = 1'b0;
            n = 0;
            while (!s_axi_bvalid && n < 200) begin
                step();
                n++;
            end
            vectors++;
            if (n !== 65 || s_axi_bresp !== ((pass == 0) ? 2'b10 : 2'b00)) begin
                miscompares++;
                $display("FAIL wr_timeout[%0d]: bvalid after %0d cycles bresp=%b, expected 65 bresp=%s",
                         pass, n, s_axi_bresp, (pass == 0) ? "10" : "00");
            end
            step();
            step();
        end
    endtask

    task automatic test_back_to_back();
        int bcyc;
        int rcyc;
        logic [1:0]  bresp_seen;
        logic [1:0]  rresp_seen;
        logic [31:0] rdata_seen;
        bcyc = -1;
        rcyc = -1;
        bresp_seen = 2'bxx;
        rresp_seen = 2'bxx;
        rdata_seen = 'x;
        wack_dly  = 3;
        rack_dly  = 1;
        rdata_val = 32'h600D_F00D;
        s_axi_bready  = 1'b1;
        s_axi_rready  = 1'b1;
        s_axi_awvalid = 1'b1;
        s_axi_awaddr  = 16'h0200;
        s_axi_wvalid  = 1'b1;
        s_axi_wdata   = 32'h0BAD_BEEF;
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = 16'h0300;
        step();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_arvalid = 1'b0;
        vectors++;
        if ({up_wreq, up_rreq, up_waddr, up_raddr} !== {2'b11, 14'h080, 14'h0C0}) begin
            miscompares++;
            $display("FAIL conc_req: wreq=%b rreq=%b waddr=%h raddr=%h expected 1/1/080/0c0",
                     up_wreq, up_rreq, up_waddr, up_raddr);
        end
        for (int i = 1; i <= 10; i++) begin
            step();
            if (s_axi_bvalid && bcyc < 0) begin
                bcyc = i;
                bresp_seen = s_axi_bresp;
            end
            if (s_axi_rvalid && rcyc < 0) begin
                rcyc = i;
                rresp_seen = s_axi_rresp;
                rdata_seen = s_axi_rdata;
            end
        end
        vectors++;
        if (bcyc !== 4 || bresp_seen !== 2'b00) begin
            miscompares++;
            $display("FAIL conc_write: bvalid at %0d bresp=%b expected 4/00", bcyc, bresp_seen);
        end
        vectors++;
        if (rcyc !== 2 || rresp_seen !== 2'b00 || rdata_seen !== 32'h600D_F00D) begin
            miscompares++;
            $display("FAIL conc_read: rvalid at %0d rresp=%b rdata=%h expected 2/00/600df00d",
                     rcyc, rresp_seen, rdata_seen);
        end
    endtask

    task automatic test_reset_in_wait();
        int base;
        int bseen;
        int n;
        base = wreq_count;
        wack_dly = 4;
        s_axi_bready  = 1'b1;
        s_axi_awvalid = 1'b1;
        s_axi_awaddr  = 16'h0010;
        s_axi_wvalid  = 1'b1;
        s_axi_wdata   = 32'h0000_0077;
        step();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        step();
        up_rstn = 1'b0;
        step();
        vectors++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
             s_axi_rvalid, s_axi_rdata, s_axi_rresp, up_wreq, up_waddr, up_wdata,
             up_rreq, up_raddr} !== '0) begin
            miscompares++;
            $display("FAIL rst_wait_outputs: outputs not all zero (bv=%b waddr=%h wdata=%h)",
                     s_axi_bvalid, up_waddr, up_wdata);
        end
        up_rstn = 1'b1;
        bseen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (s_axi_bvalid) bseen++;
        end
        vectors++;
        if (bseen !== 0 || s_axi_awready !== 1'b1 || wreq_count - base !== 1) begin
            miscompares++;
            $display("FAIL rst_wait_quiet: bvalid cycles=%0d awready=%b wreq cycles=%0d expected 0/1/1",
                     bseen, s_axi_awready, wreq_count - base);
        end
        wack_dly = 1;
        s_axi_awvalid = 1'b1;
        s_axi_awaddr  = 16'h0020;
        s_axi_wvalid  = 1'b1;
        s_axi_wdata   = 32'h0000_0099;
        step();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        vectors++;
        if ({up_wreq, up_waddr, up_wdata} !== {1'b1, 14'h008, 32'h0000_0099}) begin
            miscompares++;
            $display("FAIL rst_wait_req: wreq=%b waddr=%h wdata=%h expected 1/008/00000099",
                     up_wreq, up_waddr, up_wdata);
        end
        n = 0;
        while (!s_axi_bvalid && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (n !== 2 || s_axi_bresp !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_wait_resp: bvalid after %0d cycles bresp=%b expected 2/00", n, s_axi_bresp);
        end
        step();
    endtask

    initial begin
        up_rstn       = 1'b0;
        s_axi_awvalid = 1'b0;
        s_axi_awaddr  = '0;
        s_axi_wvalid  = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = 4'hF;
        s_axi_bready  = 1'b0;
        s_axi_arvalid = 1'b0;
        s_axi_araddr  = '0;
        s_axi_rready  = 1'b0;

        test_reset();
        test_write_same_cycle();
        test_w_before_aw();
        test_read_ack();
        test_read_timeout();
        test_write_timeout();
        test_back_to_back();
        test_reset_in_wait();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
